// File: rtl/tap_ctrl.sv
// rtl/tap_ctrl.sv - IEEE 1149.1-style TAP controller, instruction register and TDO mux
module tap_ctrl #(
    parameter int              IR_W       = 4,
    parameter logic [IR_W-1:0] IR_CAPTURE = 4'b0101,
    parameter logic [IR_W-1:0] IDCODE_OP  = 4'h1
) (
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       ID_REG_TDO,
    input  logic       BSR_TDO,
    input  logic       USERCODE_REG_TDO,
    output logic       CAPTUREDR,
    output logic       SHIFTDR,
    output logic       UPDATEDR,
    output logic       IDCODE_SELECT,
    output logic       SAMPLE_SELECT,
    output logic       EXTEST_SELECT,
    output logic       INTEST_SELECT,
    output logic       USERCODE_SELECT,
    output logic       RUNBIST_SELECT,
    output logic       GETTEST_SELECT,
    output logic       SETSTATE_SELECT,
    output logic       RUN_IDLE,
    output logic [3:0] TAP_STATE,
    output logic       TDO,
    output logic       TDO_EN
);

    typedef enum logic [3:0] {
        TLR     = 4'd0,
        RTI     = 4'd1,
        SEL_DR  = 4'd2,
        CAP_DR  = 4'd3,
        SH_DR   = 4'd4,
        EX1_DR  = 4'd5,
        PAU_DR  = 4'd6,
        EX2_DR  = 4'd7,
        UPD_DR  = 4'd8,
        SEL_IR  = 4'd9,
        CAP_IR  = 4'd10,
        SH_IR   = 4'd11,
        EX1_IR  = 4'd12,
        PAU_IR  = 4'd13,
        EX2_IR  = 4'd14,
        UPD_IR  = 4'd15
    } tap_state_t;

    tap_state_t      state;
    tap_state_t      state_nxt;
    logic [IR_W-1:0] ir;
    logic [IR_W-1:0] ir_sh;
    logic            byp;
    logic [7:0]      sel;
    logic [7:0]      ir_dec;
    logic            dr_tdo;
    logic            unused_usercode;

    // USERCODE data arrives on BSR_TDO, so this pin is deliberately left unconnected.
    assign unused_usercode = USERCODE_REG_TDO;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state <= TLR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TLR:     state_nxt = TMS ? TLR    : RTI;
            RTI:     state_nxt = TMS ? SEL_DR : RTI;
            SEL_DR:  state_nxt = TMS ? SEL_IR : CAP_DR;
            CAP_DR:  state_nxt = TMS ? EX1_DR : SH_DR;
            SH_DR:   state_nxt = TMS ? EX1_DR : SH_DR;
            EX1_DR:  state_nxt = TMS ? UPD_DR : PAU_DR;
            PAU_DR:  state_nxt = TMS ? EX2_DR : PAU_DR;
            EX2_DR:  state_nxt = TMS ? UPD_DR : SH_DR;
            UPD_DR:  state_nxt = TMS ? SEL_DR : RTI;
            SEL_IR:  state_nxt = TMS ? TLR    : CAP_IR;
            CAP_IR:  state_nxt = TMS ? EX1_IR : SH_IR;
            SH_IR:   state_nxt = TMS ? EX1_IR : SH_IR;
            EX1_IR:  state_nxt = TMS ? UPD_IR : PAU_IR;
            PAU_IR:  state_nxt = TMS ? EX2_IR : PAU_IR;
            EX2_IR:  state_nxt = TMS ? UPD_IR : SH_IR;
            UPD_IR:  state_nxt = TMS ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    always_comb begin
        CAPTUREDR = 1'b0;
        SHIFTDR   = 1'b0;
        UPDATEDR  = 1'b0;
        RUN_IDLE  = 1'b0;
        case (state)
            CAP_DR:  CAPTUREDR = 1'b1;
            SH_DR:   SHIFTDR   = 1'b1;
            UPD_DR:  UPDATEDR  = 1'b1;
            RTI:     RUN_IDLE  = 1'b1;
            default: ;
        endcase
    end

    assign TAP_STATE = state;

    // Capture, shift and update all act on the posedge that leaves the state.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir    <= IDCODE_OP;
            ir_sh <= '0;
            byp   <= 1'b0;
        end else begin
            if (state == CAP_IR) begin
                ir_sh <= IR_CAPTURE;
            end else if (state == SH_IR) begin
                ir_sh <= {TDI, ir_sh[IR_W-1:1]};
            end

            if (state == TLR) begin
                ir <= IDCODE_OP;
            end else if (state == UPD_IR) begin
                ir <= ir_sh;
            end

            if (state == CAP_DR) begin
                byp <= 1'b0;
            end else if (state == SH_DR) begin
                byp <= TDI;
            end
        end
    end

    // Opcodes 0..7 map to one select each; everything above is BYPASS.
    always_comb begin
        ir_dec = '0;
        if (ir[IR_W-1:3] == '0) begin
            ir_dec[ir[2:0]] = 1'b1;
        end
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            sel <= 8'b0000_0010;
        end else begin
            sel <= ir_dec;
        end
    end

    assign EXTEST_SELECT   = sel[0];
    assign IDCODE_SELECT   = sel[1];
    assign SAMPLE_SELECT   = sel[2];
    assign INTEST_SELECT   = sel[3];
    assign USERCODE_SELECT = sel[4];
    assign RUNBIST_SELECT  = sel[5];
    assign GETTEST_SELECT  = sel[6];
    assign SETSTATE_SELECT = sel[7];

    always_comb begin
        if (sel[1]) begin
            dr_tdo = ID_REG_TDO;
        end else if (|sel) begin
            dr_tdo = BSR_TDO;
        end else begin
            dr_tdo = byp;
        end
    end

    // TDO changes on the falling edge so the target samples it cleanly on the next rise.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            TDO    <= 1'b0;
            TDO_EN <= 1'b0;
        end else begin
            TDO_EN <= (state == SH_IR) || (state == SH_DR);
            if (state == SH_IR) begin
                TDO <= ir_sh[0];
            end else if (state == SH_DR) begin
                TDO <= dr_tdo;
            end
        end
    end

endmodule
